// File: rtl/ndf_page_reader_if.sv
// ndf_page_reader_if: request, page stream and NAND pin bundle for the page reader
interface ndf_page_reader_if;
  logic        start;
  logic [15:0] col;
  logic [23:0] row;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        ndf_r_b_n;
  logic        ndf_ce_n;
  logic        ndf_re_n;
  logic        ndf_we_n;
  logic        ndf_cle;
  logic        ndf_ale;
  logic        ndf_wp_n;
  logic [7:0]  ndf_io_o;
  logic        ndf_io_oe;
  logic [7:0]  ndf_io_i;
  modport master (
    input  start, col, row, out_ready, ndf_r_b_n, ndf_io_i,
    output busy, done, err, out_data, out_valid,
           ndf_ce_n, ndf_re_n, ndf_we_n, ndf_cle, ndf_ale, ndf_wp_n, ndf_io_o, ndf_io_oe
  );
  modport slave (
    output start, col, row, out_ready, ndf_r_b_n, ndf_io_i,
    input  busy, done, err, out_data, out_valid,
           ndf_ce_n, ndf_re_n, ndf_we_n, ndf_cle, ndf_ale, ndf_wp_n, ndf_io_o, ndf_io_oe
  );
endinterface

// File: rtl/ndf_page_reader.sv
// ndf_page_reader: NAND READ (00h, 5 addr, 30h) sequencer streaming the page out on valid/ready
module ndf_page_reader #(
  parameter int PAGE_BYTES    = 2112,
  parameter int BUSY_WAIT     = 16,
  parameter int READY_TIMEOUT = 65535
) (
  input logic               clk10,
  input logic               rst,
  ndf_page_reader_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, C0_WE, C0_REL, A_WE, A_REL, C1_WE, C1_REL,
    WAIT_BUSY, WAIT_READY, RE_LO, RE_HI, DONE
  } state_t;
  state_t      state_q, state_d;
  logic [2:0]  acnt_q, acnt_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [11:0] bcnt_q, bcnt_d;
  logic [15:0] col_q, col_d;
  logic [23:0] row_q, row_d;
  logic        err_q, err_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ce_n_q, re_n_q, we_n_q, cle_q, ale_q, oe_q, busy_q, done_q;
  logic [7:0]  io_q;
  logic        cmd_d, adr_d;
  logic [7:0]  abyte_d, io_d;
  always_comb begin
    state_d = state_q;
    acnt_d  = acnt_q;
    wcnt_d  = wcnt_q == 16'hFFFF ? wcnt_q : wcnt_q + 16'd1;
    bcnt_d  = bcnt_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = C0_WE;
        col_d   = bus.col;
        row_d   = bus.row;
        err_d   = 1'b0;
      end
      C0_WE:  state_d = C0_REL;
      C0_REL: begin
        state_d = A_WE;
        acnt_d  = 3'd0;
      end
      A_WE:   state_d = A_REL;
      A_REL:  if (acnt_q == 3'd4) state_d = C1_WE;
              else begin
                state_d = A_WE;
                acnt_d  = acnt_q + 3'd1;
              end
      C1_WE:  state_d = C1_REL;
      C1_REL: begin
        state_d = WAIT_BUSY;
        wcnt_d  = 16'd0;
      end
      // a fast array may finish before R/B# is ever seen low
      WAIT_BUSY: if (!bus.ndf_r_b_n || wcnt_q >= 16'(BUSY_WAIT - 1)) begin
        state_d = WAIT_READY;
        wcnt_d  = 16'd0;
      end
      WAIT_READY: if (bus.ndf_r_b_n) begin
        state_d = RE_LO;
        bcnt_d  = 12'd0;
      end else if (wcnt_q >= 16'(READY_TIMEOUT - 1)) begin
        state_d = DONE;
        err_d   = 1'b1;
      end
      RE_LO: begin
        state_d = RE_HI;
        data_d  = bus.ndf_io_i;
        valid_d = 1'b1;
      end
      RE_HI: if (valid_q && bus.out_ready) begin
        valid_d = 1'b0;
        if (bcnt_q == 12'(PAGE_BYTES - 1)) state_d = DONE;
        else begin
          state_d = RE_LO;
          bcnt_d  = bcnt_q + 12'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign cmd_d   = state_d inside {C0_WE, C0_REL, C1_WE, C1_REL};
  assign adr_d   = state_d inside {A_WE, A_REL};
  assign abyte_d = acnt_d == 3'd0 ? col_q[7:0]  :
                   acnt_d == 3'd1 ? col_q[15:8] :
                   acnt_d == 3'd2 ? row_q[7:0]  :
                   acnt_d == 3'd3 ? row_q[15:8] : row_q[23:16];
  assign io_d    = adr_d ? abyte_d : state_d inside {C1_WE, C1_REL} ? 8'h30 : 8'h00;
  always_ff @(posedge clk10 or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      acnt_q  <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ce_n_q  <= 1'b1;
      re_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      cle_q   <= 1'b0;
      ale_q   <= 1'b0;
      oe_q    <= 1'b0;
      io_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acnt_q  <= acnt_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      err_q   <= err_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ce_n_q  <= state_d inside {IDLE, DONE};
      re_n_q  <= state_d != RE_LO;
      we_n_q  <= !(state_d inside {C0_WE, A_WE, C1_WE});
      cle_q   <= cmd_d;
      ale_q   <= adr_d;
      oe_q    <= cmd_d || adr_d;
      io_q    <= io_d;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
    end
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.ndf_ce_n  = ce_n_q;
  assign bus.ndf_re_n  = re_n_q;
  assign bus.ndf_we_n  = we_n_q;
  assign bus.ndf_cle   = cle_q;
  assign bus.ndf_ale   = ale_q;
  assign bus.ndf_wp_n  = 1'b0;
  assign bus.ndf_io_o  = io_q;
  assign bus.ndf_io_oe = oe_q;
endmodule

// File: tb/tb_ndf_page_reader.sv
// tb_ndf_page_reader: flash model + scoreboard bench for two reader instances (full page and 8-byte page)
module tb_ndf_page_reader;
  localparam int BIG = 2112, SMALL = 8;
  logic clk10 = 1'b0, rst = 1'b1;
  logic sel = 1'b0, start = 1'b0, out_ready = 1'b1, r_b_n = 1'b1;
  logic [15:0] col = '0;
  logic [23:0] row = '0;
  int rb_mode = 1, rdy_mode = 0;
  int compared = 0, mismatched = 0;
  int done_cnt = 0, re_falls = 0, valid_cnt = 0, tick = 0, since30 = 0;
  logic armed = 1'b0, stall = 1'b0, prev_re = 1'b1, prev_we = 1'b1;
  logic [7:0] stall_data = '0;
  logic [7:0] exp_q[$];
  logic [9:0] wlog[$];
  logic [7:0] ab [5] = '{default: 8'h00};
  logic [2:0] acap = '0;
  logic [15:0] idx = '0;
  logic [7:0] flash_data;
  logic m_ce_n, m_re_n, m_we_n, m_cle, m_ale, m_wp_n, m_oe, m_busy, m_done, m_err, m_valid;
  logic [7:0] m_io_o, m_data;

  always #50 clk10 = ~clk10;

  ndf_page_reader_if bus_a ();
  ndf_page_reader_if bus_b ();
  ndf_page_reader u_big (.clk10(clk10), .rst(rst), .bus(bus_a));
  ndf_page_reader #(.PAGE_BYTES(SMALL)) u_small (.clk10(clk10), .rst(rst), .bus(bus_b));

  assign bus_a.start = start & ~sel;
  assign bus_b.start = start & sel;
  assign bus_a.col = col;
  assign bus_b.col = col;
  assign bus_a.row = row;
  assign bus_b.row = row;
  assign bus_a.out_ready = out_ready;
  assign bus_b.out_ready = out_ready;
  assign bus_a.ndf_r_b_n = r_b_n;
  assign bus_b.ndf_r_b_n = r_b_n;
  assign bus_a.ndf_io_i = flash_data;
  assign bus_b.ndf_io_i = flash_data;
  assign m_ce_n  = sel ? bus_b.ndf_ce_n  : bus_a.ndf_ce_n;
  assign m_re_n  = sel ? bus_b.ndf_re_n  : bus_a.ndf_re_n;
  assign m_we_n  = sel ? bus_b.ndf_we_n  : bus_a.ndf_we_n;
  assign m_cle   = sel ? bus_b.ndf_cle   : bus_a.ndf_cle;
  assign m_ale   = sel ? bus_b.ndf_ale   : bus_a.ndf_ale;
  assign m_wp_n  = sel ? bus_b.ndf_wp_n  : bus_a.ndf_wp_n;
  assign m_oe    = sel ? bus_b.ndf_io_oe : bus_a.ndf_io_oe;
  assign m_io_o  = sel ? bus_b.ndf_io_o  : bus_a.ndf_io_o;
  assign m_busy  = sel ? bus_b.busy      : bus_a.busy;
  assign m_done  = sel ? bus_b.done      : bus_a.done;
  assign m_err   = sel ? bus_b.err       : bus_a.err;
  assign m_valid = sel ? bus_b.out_valid : bus_a.out_valid;
  assign m_data  = sel ? bus_b.out_data  : bus_a.out_data;

  // page contents as a pure function of the flash address
  function automatic logic [7:0] pbyte(input logic [23:0] r, input logic [15:0] c);
    return 8'(r[7:0] + 8'd3 * r[15:8] + 8'd7 * r[23:16]) ^ c[7:0] ^ 8'(c[15:8] * 8'd5);
  endfunction

  assign flash_data = pbyte({ab[4], ab[3], ab[2]}, {ab[1], ab[0]} + idx);

  // flash side: latch address bytes on WE# and advance the read pointer on each RE# pulse
  always @(posedge clk10) begin
    if (!m_we_n && m_cle && m_io_o == 8'h00) acap <= 3'd0;
    else if (!m_we_n && m_ale && acap < 3'd5) begin
      ab[acap] <= m_io_o;
      acap <= acap + 3'd1;
    end
    if (!m_we_n && m_cle && m_io_o == 8'h30) idx <= '0;
    else if (!m_re_n) idx <= idx + 16'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_step();
    logic [7:0] e;
    out_ready = rdy_mode == 1 ? (tick % 3 == 0) : rdy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
    tick++;
    since30++;
    r_b_n = rb_mode == 1 ? 1'b1 : rb_mode == 2 ? !armed : !(armed && since30 >= 3 && since30 < 203);
    if (rst) begin
      stall = 1'b0;
      prev_re = 1'b1;
      prev_we = 1'b1;
      return;
    end
    if (!prev_we && m_we_n) begin
      wlog.push_back({m_cle, m_ale, m_io_o});
      if (m_cle && m_io_o == 8'h30) begin
        armed = 1'b1;
        since30 = 0;
      end else if (m_cle && m_io_o == 8'h00) armed = 1'b0;
    end
    prev_we = m_we_n;
    if (prev_re && !m_re_n) re_falls++;
    prev_re = m_re_n;
    if (m_done) done_cnt++;
    if (m_valid) begin
      valid_cnt++;
      if (stall) begin
        chk("stall_data", m_data, stall_data);
        chk("stall_re_high", m_re_n, 1);
      end
      if (out_ready) begin
        if (exp_q.size() == 0) chk("extra_byte", m_data, 9'h100);
        else begin
          e = exp_q.pop_front();
          chk("stream_byte", m_data, e);
        end
      end
      stall = !out_ready;
      stall_data = m_data;
    end else begin
      if (stall) chk("valid_dropped", m_valid, 1);
      stall = 1'b0;
    end
  endtask

  task automatic check_rst(input string name);
    chk(name, {m_ce_n, m_re_n, m_we_n, m_cle, m_ale, m_wp_n, m_oe, m_io_o,
               m_busy, m_done, m_err, m_valid, m_data}, 27'h7000000);
  endtask

  task automatic do_start(input logic [15:0] c, input logic [23:0] r, input bit push);
    int pb = sel ? SMALL : BIG;
    @(negedge clk10);
    col = c;
    row = r;
    start = 1'b1;
    if (push) for (int i = 0; i < pb; i++) exp_q.push_back(pbyte(r, c + 16'(i)));
    @(posedge clk10);
    @(negedge clk10);
    start = 1'b0;
    chk("busy_cycle1", m_busy, 1);
    chk("err_cleared", m_err, 0);
  endtask

  task automatic cmd_check(input logic [15:0] c, input logic [23:0] r, input int w0);
    logic [9:0] ew [7];
    ew = '{{2'b10, 8'h00}, {2'b01, c[7:0]}, {2'b01, c[15:8]}, {2'b01, r[7:0]},
           {2'b01, r[15:8]}, {2'b01, r[23:16]}, {2'b10, 8'h30}};
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) @(negedge clk10);
      chk($sformatf("we_n_cycle%0d", k), m_we_n, (k % 2 == 0));
      chk($sformatf("ce_n_cycle%0d", k), m_ce_n, 0);
    end
    repeat (2) @(negedge clk10);
    chk("bus_write_count", wlog.size() - w0, 7);
    for (int i = 0; i < 7; i++) chk($sformatf("bus_write%0d", i), wlog[w0 + i], ew[i]);
  endtask

  task automatic wait_done(input int budget, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk10);
      n++;
    end
    chk("done_in_budget", done_cnt != d0, 1);
    repeat (4) @(negedge clk10);
    chk("done_once", done_cnt - d0, 1);
  endtask

  task automatic do_read(input bit s, input logic [15:0] c, input logic [23:0] r, input int rbm,
                         input int rdm, input bit exp_err, input bit cmdchk, input bit latchk,
                         input int budget);
    int d0, r0, v0, w0, k;
    int pb;
    sel = s;
    pb = s ? SMALL : BIG;
    rb_mode = rbm;
    rdy_mode = rdm;
    d0 = done_cnt;
    r0 = re_falls;
    v0 = valid_cnt;
    w0 = wlog.size();
    do_start(c, r, !exp_err);
    if (cmdchk) cmd_check(c, r, w0);
    else if (latchk) begin
      k = 1;
      while (!m_valid && k < 100) begin
        @(negedge clk10);
        k++;
      end
      chk("first_valid_cycle", k, 33);
    end
    wait_done(budget, d0);
    chk("queue_drained", exp_q.size(), 0);
    chk("err_flag", m_err, exp_err);
    chk("busy_after", m_busy, 0);
    chk("re_fall_count", re_falls - r0, exp_err ? 0 : pb);
    if (exp_err) chk("no_valid", valid_cnt - v0, 0);
    exp_q.delete();
  endtask

  initial begin
    int r0, n;
    fork
      forever begin
        @(negedge clk10);
        mon_step();
      end
    join_none
    @(negedge clk10);
    check_rst("reset_values");
    repeat (3) @(negedge clk10);
    rst = 1'b0;
    repeat (2) @(negedge clk10);
    do_read(1'b0, 16'h0000, 24'h012345, 0, 0, 1'b0, 1'b1, 1'b0, 6000);
    do_read(1'b1, 16'($urandom), 24'($urandom), 1, 0, 1'b0, 1'b0, 1'b1, 300);
    do_read(1'b1, 16'($urandom), 24'($urandom), 2, 0, 1'b1, 1'b0, 1'b0, 70000);
    do_read(1'b1, 16'($urandom), 24'($urandom), 0, 1, 1'b0, 1'b1, 1'b0, 600);
    for (int i = 0; i < 3; i++)
      do_read(1'b1, 16'($urandom), 24'($urandom), int'($urandom_range(0, 1)), 2, 1'b0, 1'b0, 1'b0, 600);
    sel = 1'b1;
    rb_mode = 0;
    rdy_mode = 0;
    do_start(16'($urandom), 24'($urandom), 1'b1);
    repeat (5) @(negedge clk10);
    #10 rst = 1'b1;
    #1 check_rst("reset_in_address");
    exp_q.delete();
    repeat (2) @(negedge clk10);
    rst = 1'b0;
    rb_mode = 1;
    rdy_mode = 1;
    r0 = re_falls;
    do_start(16'($urandom), 24'($urandom), 1'b1);
    n = 0;
    while (re_falls - r0 < 3 && n < 300) begin
      @(negedge clk10);
      n++;
    end
    chk("stream_started", re_falls - r0 >= 3, 1);
    #10 rst = 1'b1;
    #1 check_rst("reset_in_stream");
    exp_q.delete();
    repeat (2) @(negedge clk10);
    rst = 1'b0;
    do_read(1'b1, 16'($urandom), 24'($urandom), 0, 1, 1'b0, 1'b1, 1'b0, 600);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
